// File: rtl/lw_hazard_ctrl_if.sv
// Bus between the ID-stage hazard/stall controller and the pipeline registers.
// The master side drives the hazard inputs; the slave side is the controller.
interface lw_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTR_W  = 3,
  parameter int unsigned PERF_W = 16
);
  logic [CTR_W-1:0]  IdExMemOutCtr;
  logic [REG_AW-1:0] IdExRt;
  logic [REG_AW-1:0] IfIdRs;
  logic [REG_AW-1:0] IfIdRt;
  logic              IfIdUsesRs;
  logic              IfIdUsesRt;
  logic              BranchTaken;
  logic              MemBusy;
  logic              Stall;
  logic              PCen;
  logic              IfIden;
  logic              IfIdFlush;
  logic              IdExEn;
  logic              IdExFlush;
  logic              ExMemEn;
  logic [PERF_W-1:0] StallCount;

  modport master (
    output IdExMemOutCtr, IdExRt, IfIdRs, IfIdRt, IfIdUsesRs, IfIdUsesRt, BranchTaken, MemBusy,
    input  Stall, PCen, IfIden, IfIdFlush, IdExEn, IdExFlush, ExMemEn, StallCount
  );

  modport slave (
    input  IdExMemOutCtr, IdExRt, IfIdRs, IfIdRt, IfIdUsesRs, IfIdUsesRt, BranchTaken, MemBusy,
    output Stall, PCen, IfIden, IfIdFlush, IdExEn, IdExFlush, ExMemEn, StallCount
  );
endinterface

// File: rtl/lw_hazard_ctrl.sv
// Load-use hazard and stall controller for the ID stage: multi-cycle load stalls,
// memory-busy freeze, branch flush of IF/ID and a saturating stall-cycle counter.
module lw_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned CTR_W    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned PERF_W   = 16
) (
  input logic             clk,
  input logic             rst_n,
  lw_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e            stateQ, stateD;
  logic [3:0]        cntQ, cntD;
  logic [PERF_W-1:0] countQ, countD;

  logic haz;
  logic stall;
  logic frozen;

  // $0 never carries a hazard, and only operands actually read count.
  assign haz = (bus.IdExMemOutCtr != '0) && (bus.IdExRt != '0) &&
               ((bus.IfIdUsesRs && (bus.IdExRt == bus.IfIdRs)) ||
                (bus.IfIdUsesRt && (bus.IdExRt == bus.IfIdRt)));

  // Outputs are forced to their idle values while reset is held.
  assign stall  = rst_n && ((stateQ == StStall) || haz);
  assign frozen = rst_n && bus.MemBusy;

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    countD = countQ;
    if (!bus.MemBusy) begin
      unique case (stateQ)
        StIdle: begin
          if (haz && (LOAD_LAT > 1)) begin
            stateD = StStall;
            cntD   = 4'(LOAD_LAT - 1);
          end
        end
        StStall: begin
          cntD = cntQ - 4'd1;
          if (cntQ == 4'd1) begin
            stateD = StIdle;
          end
        end
        default: stateD = StIdle;
      endcase
      if (stall && (countQ != '1)) begin
        countD = countQ + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      countQ <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      countQ <= countD;
    end
  end

  always_comb begin
    bus.Stall     = stall;
    bus.PCen      = ~stall;
    bus.IfIden    = ~stall;
    bus.IdExEn    = 1'b1;
    bus.ExMemEn   = 1'b1;
    bus.IdExFlush = stall;
    // A branch waiting on a load operand resolves only once the stall ends.
    bus.IfIdFlush = rst_n && bus.BranchTaken && ~stall;
    if (frozen) begin
      bus.PCen      = 1'b0;
      bus.IfIden    = 1'b0;
      bus.IdExEn    = 1'b0;
      bus.ExMemEn   = 1'b0;
      bus.IdExFlush = 1'b0;
      bus.IfIdFlush = 1'b0;
    end
  end

  assign bus.StallCount = countQ;

endmodule

// File: tb/tb_lw_hazard_ctrl.sv
// Directed bench for lw_hazard_ctrl: three instances cover LOAD_LAT=1, LOAD_LAT=3 and
// a narrow 4-bit stall counter, each with its own reset.
module tb_lw_hazard_ctrl;

  logic clk = 1'b0;
  logic rstA, rstB, rstC;
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 clk = ~clk;

  lw_hazard_ctrl_if #(.REG_AW(5), .CTR_W(3), .PERF_W(16)) busA ();
  lw_hazard_ctrl_if #(.REG_AW(5), .CTR_W(3), .PERF_W(16)) busB ();
  lw_hazard_ctrl_if #(.REG_AW(5), .CTR_W(3), .PERF_W(4))  busC ();

  lw_hazard_ctrl #(.REG_AW(5), .CTR_W(3), .LOAD_LAT(1), .PERF_W(16)) dutA (
    .clk(clk), .rst_n(rstA), .bus(busA.slave));
  lw_hazard_ctrl #(.REG_AW(5), .CTR_W(3), .LOAD_LAT(3), .PERF_W(16)) dutB (
    .clk(clk), .rst_n(rstB), .bus(busB.slave));
  lw_hazard_ctrl #(.REG_AW(5), .CTR_W(3), .LOAD_LAT(3), .PERF_W(4)) dutC (
    .clk(clk), .rst_n(rstC), .bus(busC.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drvA(input logic [2:0] ctr, input logic [4:0] exRt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic useRs, input logic useRt,
                      input logic br, input logic busy);
    busA.IdExMemOutCtr = ctr; busA.IdExRt = exRt; busA.IfIdRs = rs; busA.IfIdRt = rt;
    busA.IfIdUsesRs = useRs; busA.IfIdUsesRt = useRt; busA.BranchTaken = br;
    busA.MemBusy = busy;
    #1;
  endtask

  task automatic drvB(input logic [2:0] ctr, input logic [4:0] exRt, input logic [4:0] rs,
                      input logic busy);
    busB.IdExMemOutCtr = ctr; busB.IdExRt = exRt; busB.IfIdRs = rs; busB.IfIdRt = 5'd0;
    busB.IfIdUsesRs = 1'b1; busB.IfIdUsesRt = 1'b0; busB.BranchTaken = 1'b0;
    busB.MemBusy = busy;
    #1;
  endtask

  task automatic drvC(input logic [2:0] ctr, input logic [4:0] exRt, input logic [4:0] rt);
    busC.IdExMemOutCtr = ctr; busC.IdExRt = exRt; busC.IfIdRs = 5'd0; busC.IfIdRt = rt;
    busC.IfIdUsesRs = 1'b0; busC.IfIdUsesRt = 1'b1; busC.BranchTaken = 1'b0;
    busC.MemBusy = 1'b0;
    #1;
  endtask

  initial begin
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    drvB(3'd0, 5'd0, 5'd0, 1'b0);
    drvC(3'd0, 5'd0, 5'd0);
    // Hazard and busy present during reset must not leak to the outputs.
    drvA(3'd1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_stall", busA.Stall, 0);
    chk("rst_pcen", busA.PCen, 1);
    chk("rst_idexen", busA.IdExEn, 1);
    chk("rst_exmemen", busA.ExMemEn, 1);
    chk("rst_ififlush", busA.IfIdFlush, 0);
    chk("rst_idexflush", busA.IdExFlush, 0);
    chk("rst_count", busA.StallCount, 0);
    tick();
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;

    // LOAD_LAT=1 single-cycle load-use stall
    drvA(3'd1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_stall", busA.Stall, 1);
    chk("t1_pcen", busA.PCen, 0);
    chk("t1_ifiden", busA.IfIden, 0);
    chk("t1_idexflush", busA.IdExFlush, 1);
    chk("t1_idexen", busA.IdExEn, 1);
    tick();
    drvA(3'd0, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_stall_off", busA.Stall, 0);
    chk("t1_pcen_on", busA.PCen, 1);
    chk("t1_count", busA.StallCount, 1);

    // $0 and unread operands never stall; a read rt does
    drvA(3'd1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_reg0", busA.Stall, 0);
    drvA(3'd1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_rt_unused", busA.Stall, 0);
    drvA(3'd1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_rt_used", busA.Stall, 1);
    drvA(3'd0, 5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_not_load", busA.Stall, 0);

    // Branch flush is held off while a stall is pending
    drvA(3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_flush", busA.IfIdFlush, 1);
    chk("t5_pcen", busA.PCen, 1);
    drvA(3'd1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_flush_held", busA.IfIdFlush, 0);
    tick();
    drvA(3'd0, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_flush_late", busA.IfIdFlush, 1);
    chk("t5_count", busA.StallCount, 2);

    // Freeze overrides everything and stops the counter
    drvA(3'd1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("fz_stall", busA.Stall, 1);
    chk("fz_pcen", busA.PCen, 0);
    chk("fz_idexen", busA.IdExEn, 0);
    chk("fz_exmemen", busA.ExMemEn, 0);
    chk("fz_idexflush", busA.IdExFlush, 0);
    chk("fz_ififlush", busA.IfIdFlush, 0);
    tick();
    chk("fz_count", busA.StallCount, 2);

    // LOAD_LAT=3: three consecutive stall cycles
    drvB(3'd1, 5'd4, 5'd4, 1'b0);
    chk("t3_s0", busB.Stall, 1);
    tick();
    drvB(3'd0, 5'd4, 5'd4, 1'b0);
    chk("t3_s1", busB.Stall, 1);
    tick();
    chk("t3_s2", busB.Stall, 1);
    tick();
    chk("t3_s3", busB.Stall, 0);
    chk("t3_count", busB.StallCount, 3);

    // LOAD_LAT=3 with a two-cycle freeze starting at t+1
    drvB(3'd1, 5'd4, 5'd4, 1'b0);
    chk("t4_s0", busB.Stall, 1);
    tick();
    drvB(3'd0, 5'd4, 5'd4, 1'b1);
    chk("t4_fz_stall", busB.Stall, 1);
    chk("t4_fz_pcen", busB.PCen, 0);
    chk("t4_fz_ifiden", busB.IfIden, 0);
    chk("t4_fz_idexen", busB.IdExEn, 0);
    chk("t4_fz_exmemen", busB.ExMemEn, 0);
    tick();
    chk("t4_fz_count", busB.StallCount, 4);
    tick();
    drvB(3'd0, 5'd4, 5'd4, 1'b0);
    chk("t4_s3", busB.Stall, 1);
    tick();
    chk("t4_s4", busB.Stall, 1);
    tick();
    chk("t4_s5", busB.Stall, 0);
    chk("t4_count", busB.StallCount, 6);

    // PERF_W=4 saturation after 20 continuous stall cycles
    drvC(3'd2, 5'd7, 5'd7);
    for (int i = 0; i < 20; i++) begin
      if (i == 15) chk("t6_count15", busC.StallCount, 15);
      tick();
    end
    chk("t6_sat", busC.StallCount, 15);
    drvC(3'd0, 5'd7, 5'd7);
    chk("t6_mid_stall", busC.Stall, 1);
    rstC = 1'b0;
    #1;
    chk("t6_rst_stall", busC.Stall, 0);
    chk("t6_rst_count", busC.StallCount, 0);
    chk("t6_rst_pcen", busC.PCen, 1);
    @(negedge clk);
    rstC = 1'b1;
    tick();
    chk("t6_post_stall", busC.Stall, 0);
    tick();
    chk("t6_post_count", busC.StallCount, 0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
